// File: rtl/branch_stack.sv
// Branch stack: one-hot branch IDs, dependency masks and recovery checkpoints.
// Resolutions from the branch FU become registered CLEAR / SQUASH broadcasts.
module branch_stack #(
  parameter int DEPTH  = 4,
  parameter int CKPT_W = 48,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_req,
  input  logic [CKPT_W-1:0] alloc_ckpt,
  output logic              alloc_gnt,
  output logic [DEPTH-1:0]  alloc_b_id,
  output logic [DEPTH-1:0]  alloc_b_mask,
  output logic [DEPTH-1:0]  cur_b_mask,
  output logic              full,
  input  logic              res_valid,
  input  logic [1:0]        res_task,
  input  logic [DEPTH-1:0]  res_b_id,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              flush,
  output logic              clear_valid,
  output logic [DEPTH-1:0]  clear_b_id,
  output logic              squash_valid,
  output logic [DEPTH-1:0]  squash_mask,
  output logic [CKPT_W-1:0] squash_ckpt,
  output logic [ADDR_W-1:0] squash_pc
);

  localparam logic [1:0] TASK_CLEAR  = 2'd1;
  localparam logic [1:0] TASK_SQUASH = 2'd2;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  mask_q [DEPTH];
  logic [CKPT_W-1:0] ckpt_q [DEPTH];

  logic              res_onehot;
  logic              res_hit;
  logic              clr_acc;
  logic              sq_acc;
  logic [DEPTH-1:0]  kill;
  logic [DEPTH-1:0]  free;
  logic [DEPTH-1:0]  pick;
  logic [DEPTH-1:0]  clr_bit;
  logic [DEPTH-1:0]  kill_bit;
  logic [DEPTH-1:0]  drop_bit;
  logic [DEPTH-1:0]  valid_d;
  logic [CKPT_W-1:0] sel_ckpt;

  assign res_onehot = (res_b_id != '0) &&
                      ((res_b_id & (res_b_id - DEPTH'(1))) == '0);

  // a non-one-hot ID is rejected so it cannot corrupt state
  assign res_hit = res_valid && res_onehot &&
                   ((res_b_id & valid_q) != '0);

  assign clr_acc = res_hit && (res_task == TASK_CLEAR);
  assign sq_acc  = res_hit && (res_task == TASK_SQUASH);

  always_comb begin
    kill     = res_b_id;
    sel_ckpt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ((mask_q[i] & res_b_id) != '0))
        kill[i] = 1'b1;
      if (res_b_id[i])
        sel_ckpt = sel_ckpt | ckpt_q[i];
    end
  end

  assign full       = &valid_q;
  assign cur_b_mask = valid_q;

  // lowest free entry; same-cycle frees are not visible here
  assign free = ~valid_q;
  assign pick = free & (~free + DEPTH'(1));

  assign alloc_gnt = alloc_req && !full && !sq_acc &&
                     !flush && !reset;

  assign alloc_b_id = alloc_gnt ? pick : '0;

  assign clr_bit  = clr_acc ? res_b_id : '0;
  assign kill_bit = sq_acc ? kill : '0;
  assign drop_bit = (clr_acc || sq_acc) ? res_b_id : '0;

  assign alloc_b_mask = valid_q & ~clr_bit;

  assign valid_d = (valid_q & ~clr_bit & ~kill_bit) | alloc_b_id;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid_q      <= '0;
      clear_valid  <= 1'b0;
      clear_b_id   <= '0;
      squash_valid <= 1'b0;
      squash_mask  <= '0;
      squash_ckpt  <= '0;
      squash_pc    <= '0;
      for (int i = 0; i < DEPTH; i++)
        mask_q[i] <= '0;
    end else begin
      valid_q      <= valid_d;
      clear_valid  <= clr_acc;
      clear_b_id   <= clr_bit;
      squash_valid <= sq_acc;
      squash_mask  <= kill_bit;
      squash_ckpt  <= sq_acc ? sel_ckpt : '0;
      squash_pc    <= sq_acc ? res_target : '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_b_id[i]) begin
          mask_q[i] <= alloc_b_mask;
          ckpt_q[i] <= alloc_ckpt;
        end else begin
          mask_q[i] <= mask_q[i] & ~drop_bit;
        end
      end
    end
  end

  a_res_onehot: assert property (
    @(posedge clock) disable iff (reset)
    (res_valid && res_task != 2'd0) |-> $onehot(res_b_id)
  );

endmodule

// File: tb/tb_branch_stack.sv
// Randomized scoreboard bench for branch_stack against an age-ordered
// list model of in-flight branches.
module tb_branch_stack;

  logic        clock;
  logic        reset;
  logic        alloc_req;
  logic [47:0] alloc_ckpt;
  logic        alloc_gnt;
  logic [3:0]  alloc_b_id;
  logic [3:0]  alloc_b_mask;
  logic [3:0]  cur_b_mask;
  logic        full;
  logic        res_valid;
  logic [1:0]  res_task;
  logic [3:0]  res_b_id;
  logic [31:0] res_target;
  logic        flush;
  logic        clear_valid;
  logic [3:0]  clear_b_id;
  logic        squash_valid;
  logic [3:0]  squash_mask;
  logic [47:0] squash_ckpt;
  logic [31:0] squash_pc;

  branch_stack #(.DEPTH(4), .CKPT_W(48), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_ckpt(alloc_ckpt),
    .alloc_gnt(alloc_gnt), .alloc_b_id(alloc_b_id),
    .alloc_b_mask(alloc_b_mask), .cur_b_mask(cur_b_mask),
    .full(full), .res_valid(res_valid), .res_task(res_task),
    .res_b_id(res_b_id), .res_target(res_target), .flush(flush),
    .clear_valid(clear_valid), .clear_b_id(clear_b_id),
    .squash_valid(squash_valid), .squash_mask(squash_mask),
    .squash_ckpt(squash_ckpt), .squash_pc(squash_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          cv;
    logic [3:0]  cid;
    bit          sv;
    logic [3:0]  smask;
    logic [47:0] sckpt;
    logic [31:0] spc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   started = 0;

  // in-flight branches, oldest first
  int          live_slot[$];
  logic [47:0] live_ckpt[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] live_set();
    logic [3:0] s;
    s = 4'b0000;
    foreach (live_slot[i]) s[live_slot[i]] = 1'b1;
    return s;
  endfunction

  task automatic step(input bit areq, input logic [47:0] ck,
                      input bit rv, input logic [1:0] tk,
                      input logic [3:0] id, input logic [31:0] tg,
                      input bit fl, input bit rs);
    logic [3:0] set;
    logic [3:0] bid_e;
    logic [3:0] bmask_e;
    logic [3:0] kill;
    bit         onehot, hit, clr, sq, gnt, full_e;
    int         k, slot, pos;
    exp_t       e;
    @(posedge clock);
    #1;
    alloc_req  = areq;
    alloc_ckpt = ck;
    res_valid  = rv;
    res_task   = tk;
    res_b_id   = id;
    res_target = tg;
    flush      = fl;
    reset      = rs;
    #4;
    set    = live_set();
    full_e = (live_slot.size() == 4);
    onehot = $onehot(id);
    hit    = rv && onehot && ((id & set) != 4'b0000);
    clr    = hit && (tk == 2'd1);
    sq     = hit && (tk == 2'd2);
    gnt    = areq && !full_e && !sq && !fl && !rs;
    k = 0;
    for (int i = 0; i < 4; i++) if (id[i]) k = i;
    slot = 0;
    for (int i = 3; i >= 0; i--) if (!set[i]) slot = i;
    bid_e   = gnt ? (4'b0001 << slot) : 4'b0000;
    bmask_e = clr ? (set & ~id) : set;
    chk("alloc_gnt", 64'(alloc_gnt), 64'(gnt));
    chk("alloc_b_id", 64'(alloc_b_id), 64'(bid_e));
    chk("alloc_b_mask", 64'(alloc_b_mask), 64'(bmask_e));
    chk("cur_b_mask", 64'(cur_b_mask), 64'(set));
    chk("full", 64'(full), 64'(full_e));
    e = '{cv: 0, cid: 0, sv: 0, smask: 0, sckpt: 0, spc: 0};
    if (rs || fl) begin
      live_slot.delete();
      live_ckpt.delete();
    end else begin
      pos = -1;
      foreach (live_slot[i]) if (live_slot[i] == k) pos = i;
      if (clr) begin
        e.cv = 1; e.cid = id;
        live_slot.delete(pos);
        live_ckpt.delete(pos);
      end
      if (sq) begin
        kill = 4'b0000;
        for (int i = pos; i < live_slot.size(); i++)
          kill[live_slot[i]] = 1'b1;
        e.sv = 1; e.smask = kill;
        e.sckpt = live_ckpt[pos]; e.spc = tg;
        while (live_slot.size() > pos) begin
          void'(live_slot.pop_back());
          void'(live_ckpt.pop_back());
        end
      end
      if (gnt) begin
        live_slot.push_back(slot);
        live_ckpt.push_back(ck);
      end
    end
    sb.push_back(e);
    started = 1;
  endtask

  always @(posedge clock) begin
    exp_t e;
    #3;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("clear_valid", 64'(clear_valid), 64'(e.cv));
      chk("clear_b_id", 64'(clear_b_id), 64'(e.cid));
      chk("squash_valid", 64'(squash_valid), 64'(e.sv));
      chk("squash_mask", 64'(squash_mask), 64'(e.smask));
      chk("squash_ckpt", 64'(squash_ckpt), 64'(e.sckpt));
      chk("squash_pc", 64'(squash_pc), 64'(e.spc));
    end else if (started && (clear_valid || squash_valid)) begin
      chk("unexpected_pulse", 64'({clear_valid, squash_valid}), 64'(0));
    end
  end

  task automatic alloc(input logic [47:0] ck);
    step(1, ck, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic res(input logic [1:0] tk, input logic [3:0] id,
                     input logic [31:0] tg, input bit areq);
    step(areq, 48'h99, 1, tk, id, tg, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_flush();
    step(1, 48'h5, 1, 2'd1, 4'b0001, 0, 1, 0);
  endtask

  task automatic fill4();
    alloc(48'h11); alloc(48'h22); alloc(48'h33); alloc(48'h44);
  endtask

  initial begin
    bit          rv, fl, rs, ar;
    logic [1:0]  tk;
    logic [3:0]  id;
    logic [47:0] ck;
    reset = 1; flush = 0; alloc_req = 0; alloc_ckpt = 0;
    res_valid = 0; res_task = 0; res_b_id = 0; res_target = 0;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 48'h7, 1, 2'd2, 4'b0001, 0, 0, 1);
    idle();
    fill4();
    alloc(48'h55);
    res(2'd1, 4'b0010, 0, 0);
    idle();
    do_flush();
    fill4();
    res(2'd2, 4'b0010, 32'h1000, 0);
    idle();
    do_flush();
    fill4();
    res(2'd2, 4'b0001, 32'h2000, 1);
    idle();
    alloc(48'hA0); alloc(48'hA1);
    res(2'd1, 4'b0001, 0, 1);
    alloc(48'hA3);
    idle();
    res(2'd1, 4'b1000, 0, 0);
    res(2'd2, 4'b1000, 32'h3000, 0);
    step(0, 0, 1, 2'd0, 4'b0001, 32'h44, 0, 0);
    res(2'd1, 4'b0010, 0, 0);
    alloc(48'hB0);
    do_flush();
    idle();
    for (int n = 0; n < 2000; n++) begin
      ar = ($urandom_range(0, 99) < 55);
      ck = {16'($urandom), $urandom};
      rv = ($urandom_range(0, 99) < 45);
      tk = 2'($urandom_range(0, 2));
      id = 4'b0001 << $urandom_range(0, 3);
      fl = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 199) < 1);
      step(ar, ck, rv, tk, id, $urandom, fl, rs);
    end
    idle();
    @(posedge clock);
    #4;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
